// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide over 32 iterations, then a
// sign-fix edge that writes HI/LO. MTHI/MTLO are honoured only while idle.
module muldiv_unit #(
    localparam int unsigned DATA_BUS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [DATA_BUS-1:0] operand_1,
    input  logic [DATA_BUS-1:0] operand_2,
    input  logic                cancel,
    input  logic                hi_write_en,
    input  logic                lo_write_en,
    input  logic [DATA_BUS-1:0] write_data,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero,
    output logic [DATA_BUS-1:0] hi,
    output logic [DATA_BUS-1:0] lo
);

    localparam int unsigned ACC_W = 2 * DATA_BUS;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DZ   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_op;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic [DATA_BUS-1:0]  r_opa;      // multiplicand, or dividend shifting out MSB-first
    logic [DATA_BUS-1:0]  r_opb;      // multiplier shifting out LSB-first, or divisor
    logic [ACC_W-1:0]     r_acc;      // product, or {remainder, quotient}
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dz;
    logic [DATA_BUS-1:0]  r_hi;
    logic [DATA_BUS-1:0]  r_lo;

    logic                 w_signed_op;
    logic                 w_zero_div;
    logic                 w_accept;
    logic [DATA_BUS-1:0]  w_mag_a;
    logic [DATA_BUS-1:0]  w_mag_b;
    logic [DATA_BUS:0]    w_mul_sum;
    logic [ACC_W-1:0]     w_mul_next;
    logic [DATA_BUS:0]    w_rem_sh;
    logic [DATA_BUS+1:0]  w_diff;
    logic [ACC_W-1:0]     w_div_next;
    logic [ACC_W-1:0]     w_prod_fix;
    logic [DATA_BUS-1:0]  w_quo_fix;
    logic [DATA_BUS-1:0]  w_rem_fix;

    // Request decode and operand magnitudes for the accept edge.
    assign w_signed_op = ~op[0];
    assign w_zero_div  = op[1] && (operand_2 == '0);
    assign w_accept    = (r_state == S_IDLE) && start && !cancel;
    assign w_mag_a     = (w_signed_op && operand_1[DATA_BUS-1]) ? -operand_1 : operand_1;
    assign w_mag_b     = (w_signed_op && operand_2[DATA_BUS-1]) ? -operand_2 : operand_2;

    // One shift-add multiply step: add into upper 33 bits, then shift {carry, acc} right.
    assign w_mul_sum  = {1'b0, r_acc[ACC_W-1:DATA_BUS]} + (r_opb[0] ? {1'b0, r_opa} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[DATA_BUS-1:1]};

    // One restoring-divide step: shift in the next dividend bit and trial-subtract.
    assign w_rem_sh   = {r_acc[ACC_W-1:DATA_BUS], r_opa[DATA_BUS-1]};
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opb};
    assign w_div_next = w_diff[DATA_BUS+1]
                      ? {w_rem_sh[DATA_BUS-1:0], r_acc[DATA_BUS-2:0], 1'b0}
                      : {w_diff[DATA_BUS-1:0],   r_acc[DATA_BUS-2:0], 1'b1};

    // Sign correction applied on the FIX edge.
    assign w_prod_fix = ((r_op == 2'b00) && (r_sign_a ^ r_sign_b)) ? -r_acc : r_acc;
    assign w_quo_fix  = ((r_op == 2'b10) && (r_sign_a ^ r_sign_b))
                      ? -r_acc[DATA_BUS-1:0] : r_acc[DATA_BUS-1:0];
    assign w_rem_fix  = ((r_op == 2'b10) && r_sign_a)
                      ? -r_acc[ACC_W-1:DATA_BUS] : r_acc[ACC_W-1:DATA_BUS];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; cancel returns any active state to IDLE.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (start && !cancel) w_next_state = w_zero_div ? S_DZ : S_CALC;
            S_CALC: begin
                if (cancel)                       w_next_state = S_IDLE;
                else if (r_cnt == CNT_W'(31))     w_next_state = S_FIX;
            end
            S_FIX:  w_next_state = S_IDLE;
            S_DZ:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath, HI/LO and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (hi_write_en) r_hi <= write_data;
                    if (lo_write_en) r_lo <= write_data;
                    if (w_accept) begin
                        r_op     <= op;
                        r_sign_a <= operand_1[DATA_BUS-1];
                        r_sign_b <= operand_2[DATA_BUS-1];
                        r_opa    <= w_mag_a;
                        r_opb    <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_op[1]) begin
                            r_acc <= w_div_next;
                            r_opa <= r_opa << 1;
                        end else begin
                            r_acc <= w_mul_next;
                            r_opb <= r_opb >> 1;
                        end
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (!cancel) begin
                        r_done <= 1'b1;
                        if (r_op[1]) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[ACC_W-1:DATA_BUS];
                            r_lo <= w_prod_fix[DATA_BUS-1:0];
                        end
                    end
                end
                S_DZ: begin
                    r_busy <= 1'b0;
                    if (!cancel) begin
                        r_done <= 1'b1;
                        r_dz   <= 1'b1;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        cancel;
    logic        hi_write_en;
    logic        lo_write_en;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_1(operand_1), .operand_2(operand_2), .cancel(cancel),
        .hi_write_en(hi_write_en), .lo_write_en(lo_write_en), .write_data(write_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Architectural result {HI, LO} from ordinary integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            2'd0: begin p = sa * sb; return 64'(p); end
            2'd1: return ua * ub;
            2'd2: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
            default: return {a % b, a / b};
        endcase
    endfunction

    // Issue one op at the current negedge and follow it to completion.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        bit dz_case, seen, busy_ok;
        int lat, want_lat;
        dz_case  = o[1] && (b == 32'h0);
        exp      = dz_case ? {model_hi, model_lo} : ref_result(o, a, b);
        want_lat = dz_case ? 1 : 33;
        start = 1'b1; op = o; operand_1 = a; operand_2 = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); operand_1 = $urandom; operand_2 = $urandom;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0", tag, busy, done);
        end
        seen = 0; lat = 0; busy_ok = 1;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1; lat = k; end
            else if (busy !== 1'b1) busy_ok = 0;
        end
        n_cmp++;
        if (!seen || lat != want_lat) begin
            n_bad++; $display("FAIL %s latency: got %0d (seen=%0d) want %0d", tag, lat, seen, want_lat);
        end
        n_cmp++;
        if (!busy_ok || busy !== 1'b0) begin
            n_bad++; $display("FAIL %s busy: held=%0d at_done=%b want held=1 at_done=0", tag, busy_ok, busy);
        end
        n_cmp++;
        if (div_by_zero !== dz_case) begin
            n_bad++; $display("FAIL %s div_by_zero: got %b want %b", tag, div_by_zero, dz_case);
        end
        n_cmp++;
        if (hi !== exp[63:32] || lo !== exp[31:0]) begin
            n_bad++; $display("FAIL %s hilo: got %h_%h want %h_%h", tag, hi, lo, exp[63:32], exp[31:0]);
        end
        model_hi = exp[63:32];
        model_lo = exp[31:0];
    endtask

    // MTHI/MTLO strobe for one cycle from the current negedge.
    task automatic mt_write(input logic he, input logic le, input logic [31:0] d);
        hi_write_en = he; lo_write_en = le; write_data = d;
        @(negedge clk);
        hi_write_en = 1'b0; lo_write_en = 1'b0;
        if (he) model_hi = d;
        if (le) model_lo = d;
    endtask

    task automatic test_reset;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_bad++; $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_by_zero, hi, lo);
        end
    endtask

    task automatic test_mtlo;
        mt_write(1'b0, 1'b1, 32'h0000ABCD);
        n_cmp++;
        if (lo !== 32'h0000ABCD || hi !== model_hi) begin
            n_bad++; $display("FAIL mtlo: hi=%h lo=%h want hi=%h lo=0000abcd", hi, lo, model_hi);
        end
        mt_write(1'b1, 1'b0, 32'h12345678);
        n_cmp++;
        if (hi !== 32'h12345678 || lo !== 32'h0000ABCD) begin
            n_bad++; $display("FAIL mthi: hi=%h lo=%h want 12345678 0000abcd", hi, lo);
        end
    endtask

    task automatic test_directed;
        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        n_cmp++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            n_bad++; $display("FAIL multu_max_const: got %h_%h want fffffffe_00000001", hi, lo);
        end
        do_op(2'd0, 32'hFFFFFFFD, 32'd5, "mult_neg3x5");
        n_cmp++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
            n_bad++; $display("FAIL mult_neg3x5_const: got %h_%h want ffffffff_fffffff1", hi, lo);
        end
        do_op(2'd2, 32'hFFFFFFF9, 32'd2, "div_neg7by2");
        n_cmp++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            n_bad++; $display("FAIL div_neg7by2_const: got %h_%h want ffffffff_fffffffd", hi, lo);
        end
        do_op(2'd0, 32'h80000000, 32'h80000000, "mult_minsq");
        n_cmp++;
        if (hi !== 32'h40000000 || lo !== 32'h0) begin
            n_bad++; $display("FAIL mult_minsq_const: got %h_%h want 40000000_00000000", hi, lo);
        end
    endtask

    task automatic test_div_zero;
        mt_write(1'b1, 1'b1, 32'h11);
        mt_write(1'b0, 1'b1, 32'h22);
        do_op(2'd3, 32'd100, 32'd0, "divu_zero");
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
            n_bad++; $display("FAIL divu_zero_after: done=%b dz=%b busy=%b hi=%h lo=%h want 0 0 0 11 22", done, div_by_zero, busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h80000000) begin
            n_bad++; $display("FAIL div_overflow_const: got %h_%h want 00000000_80000000", hi, lo);
        end
        do_op(2'd3, 32'd7, 32'd3, "divu_b2b");
        n_cmp++;
        if (hi !== 32'd1 || lo !== 32'd2) begin
            n_bad++; $display("FAIL divu_b2b_const: got %h_%h want 00000001_00000002", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_cancel;
        bit busy_ok, no_done;
        mt_write(1'b1, 1'b1, 32'h55);
        mt_write(1'b0, 1'b1, 32'h66);
        start = 1'b1; op = 2'd1; operand_1 = 32'd6; operand_2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        busy_ok = 1; no_done = 1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 0;
            if (done !== 1'b0) no_done = 0;
            if (k == 3) begin hi_write_en = 1'b1; write_data = 32'hDEAD; end
            if (k == 4) hi_write_en = 1'b0;
            if (k == 5) begin start = 1'b1; op = 2'd0; operand_1 = 32'd1; operand_2 = 32'd1; end
            if (k == 6) start = 1'b0;
            if (k == 10) cancel = 1'b1;
        end
        @(negedge clk);
        cancel = 1'b0;
        n_cmp++;
        if (!busy_ok || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL cancel_calc: held=%0d busy=%b done=%b want 1 0 0", busy_ok, busy, done);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) no_done = 0;
        end
        n_cmp++;
        if (!no_done || hi !== model_hi || lo !== model_lo) begin
            n_bad++; $display("FAIL cancel_quiet: quiet=%0d hi=%h lo=%h want 1 %h %h", no_done, hi, lo, model_hi, model_lo);
        end
        // start together with cancel in IDLE is suppressed
        start = 1'b1; cancel = 1'b1; op = 2'd1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL cancel_idle: busy=%b want 0", busy);
        end
        // cancel landing on the FIX edge suppresses the write
        start = 1'b1; op = 2'd1; operand_1 = 32'd9; operand_2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 32) cancel = 1'b1;
        end
        @(negedge clk);
        cancel = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
            n_bad++; $display("FAIL cancel_fix: done=%b busy=%b hi=%h lo=%h want 0 0 %h %h", done, busy, hi, lo, model_hi, model_lo);
        end
        // cancel landing on the DZ edge suppresses the pulses
        start = 1'b1; op = 2'd3; operand_1 = 32'd5; operand_2 = 32'd0;
        @(negedge clk);
        start = 1'b0; cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL cancel_dz: done=%b dz=%b busy=%b want 0 0 0", done, div_by_zero, busy);
        end
    endtask

    task automatic test_async_reset;
        start = 1'b1; op = 2'd3; operand_1 = 32'd1000; operand_2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_bad++; $display("FAIL async_reset: busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_by_zero, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        model_hi = 32'h0;
        model_lo = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_bad++; $display("FAIL after_reset: busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
        do_op(2'd1, 32'd6, 32'd7, "post_reset_multu");
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) mt_write(1'($urandom), 1'($urandom), $urandom);
            do_op(o, a, b, "random");
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; operand_1 = 32'h0; operand_2 = 32'h0;
        cancel = 1'b0; hi_write_en = 1'b0; lo_write_en = 1'b0; write_data = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_mtlo();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_cancel();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
